// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM link: receive FSM encoding and slot helpers.
// The last-slot helper is also used by the transmit-side sequencer.
package tdm_demux_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_CHANNELS = 4;

  function automatic int last_slot(input int channels);
    return channels - 1;
  endfunction

  localparam int DEFAULT_LAST_SLOT = last_slot(DEFAULT_CHANNELS);

endpackage

// File: rtl/tdm_demux_slot_counter.sv
// Slot position counter for the TDM receiver.
// It wraps explicitly at the last slot, so non-power-of-two frames never visit unused codes.
module slot_counter
  import tdm_demux_pkg::*;
#(
  parameter int SLOT_W   = 2,
  parameter int CHANNELS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load1,
  input  logic              clear,
  output logic [SLOT_W-1:0] slot
);

  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(last_slot(CHANNELS));

  // Priority: clear (sync lost), then load1 (sample 0 just taken), then advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else if (clear) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SLOT_W'(1);
    end else if (en) begin
      slot <= (slot == LAST) ? '0 : slot + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Receive end of the TDM link: locks onto frame sync, stages samples per slot,
// and presents each complete frame on dout with a one-cycle frame_valid pulse.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SLOT_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          din,
  input  logic                      sync,
  input  logic                      en,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic [SLOT_W-1:0]         slot,
  output logic                      frame_valid,
  output logic                      locked,
  output logic                      sync_err
);

  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(last_slot(CHANNELS));

  state_t state, state_next;

  logic start_sample;
  logic advance;
  logic early_sync;
  logic missing_sync;
  logic frame_done;

  // The last sample bypasses staging and lands directly in dout, so only CHANNELS-1 entries are kept.
  logic [WIDTH-1:0]          staging [CHANNELS-1];
  logic [CHANNELS*WIDTH-1:0] frame_word;

  always_comb begin
    start_sample = en && sync;
    advance      = en && !sync && (state == RUN) && (slot != '0);
    early_sync   = en && sync && (state == RUN) && (slot != '0);
    missing_sync = en && !sync && (state == RUN) && (slot == '0);
    frame_done   = advance && (slot == LAST);
  end

  slot_counter #(
    .SLOT_W   (SLOT_W),
    .CHANNELS (CHANNELS)
  ) u_slot_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (advance),
    .load1 (start_sample),
    .clear (missing_sync),
    .slot  (slot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      HUNT:    if (start_sample) state_next = RUN;
      RUN:     if (missing_sync) state_next = HUNT;
      default: state_next = HUNT;
    endcase
  end

  always_comb begin
    locked = (state == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CHANNELS - 1; k++) begin
        staging[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS - 1; k++) begin
        if ((start_sample && k == 0) || (advance && slot == SLOT_W'(k))) begin
          staging[k] <= din;
        end
      end
    end
  end

  always_comb begin
    frame_word = '0;
    for (int k = 0; k < CHANNELS - 1; k++) begin
      frame_word[k*WIDTH +: WIDTH] = staging[k];
    end
    frame_word[(CHANNELS-1)*WIDTH +: WIDTH] = din;
  end

  // dout only ever changes on a complete frame, so it never exposes a partial one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      if (frame_done) begin
        dout <= frame_word;
      end
      frame_valid <= frame_done;
      sync_err    <= early_sync || missing_sync;
    end
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
Receive end of the team's time-division multiplexed link. The transmit end uses 2:1 and wider muxes to steer one source at a time onto a shared data line. This block takes that shared line plus a frame-sync marker and a sample strobe, and distributes successive samples into CHANNELS parallel registered outputs. It tracks slot position, detects sync loss, and presents each complete frame atomically with a one-cycle valid pulse.

Parameters:
WIDTH, 1, bits per sample on the shared line (1 matches the existing 1-bit mux datapath)
CHANNELS, 4, channels per frame; must be >= 2; need not be a power of two
SLOT_W, 2, slot index width; must satisfy 2**SLOT_W >= CHANNELS

Ports:
Clock  input  1  system clock; all state changes on rising edge
Reset  input  1  asynchronous, active-high reset
Din  input  WIDTH  shared TDM data line
Sync  input  1  frame marker; high only together with the slot-0 sample
En  input  1  sample strobe; Din/Sync are meaningful only when En=1
Dout  output  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
Slot  output  SLOT_W  index of the next slot to be captured
FrameValid  output  1  one-cycle pulse when Dout has just been updated with a full frame
Locked  output  1  high while the state machine is in RUN
SyncErr  output  1  one-cycle pulse on a detected framing violation

Behaviour:
- Reset is asynchronous and active-high. On Reset, immediately and independent of Clock:
  - outputs: Dout=0, Slot=0, FrameValid=0, Locked=0, SyncErr=0;
  - internal: staging registers = 0, state = HUNT.
- A partial frame in progress when Reset asserts is discarded.
- FSM states: HUNT (searching for sync) and RUN (locked).
- Any cycle with En=0: no state, Slot, staging or Dout change. FrameValid=0, SyncErr=0.
- HUNT:
  - En=1, Sync=0: Din ignored, stay in HUNT.
  - En=1, Sync=1: staging[0]<=Din, Slot<=1, go to RUN.
- RUN, En=1, per edge:
  - Sync=1, Slot=0: normal frame start. staging[0]<=Din, Slot<=1.
  - Sync=0, Slot in 1..CHANNELS-1: staging[Slot]<=Din, Slot<=Slot+1.
  - Last slot (Sync=0, Slot=CHANNELS-1):
    - on that same edge, Dout<={Din, staging[CHANNELS-2..0]};
    - FrameValid=1 for exactly the following cycle;
    - Slot wraps explicitly to 0, not by binary overflow (CHANNELS=3 gives 0,1,2,0);
    - latency is one edge from the last sample to Dout/FrameValid.
  - Sync=1, Slot!=0 (early sync):
    - SyncErr=1 for the next cycle;
    - partial frame discarded, Dout unchanged, no FrameValid;
    - resync on this sample: staging[0]<=Din, Slot<=1, stay in RUN.
  - Sync=0, Slot=0 (missing sync):
    - SyncErr=1 for the next cycle;
    - go to HUNT, Slot stays 0, Din discarded, Dout unchanged.
- Dout holds the last complete frame until the next complete frame or Reset. It never shows a partial frame.
- Staging registers are not cleared on resync. Stale entries are always overwritten before the next Dout transfer.
- FrameValid and SyncErr are never high in the same cycle.
- Sync or Din while En=0 is ignored, with no error.

Decomposition:
- Shared package: FSM state encoding (HUNT=0, RUN=1).
- Shared package: a helper constant for the last slot index (CHANNELS-1), reused by the transmit-side sequencer.
- One sub-module, slot_counter:
  - parameters: SLOT_W, CHANNELS;
  - inputs: Clock, Reset, En, Load1, Clear;
  - output: Slot;
  - behaviour: wraps from CHANNELS-1 to 0.
- The FSM, staging array and output register stay in tdm_demux.

Test Plan:
1. Lock and capture (CHANNELS=4, WIDTH=1):
   - stimulus: En=1 every cycle, Sync=1 with the first sample, Din=1,0,1,1;
   - response: Locked=1 after the first edge; after the 4th edge Dout=4'b1101 (ch0=1, ch1=0, ch2=1, ch3=1) and FrameValid=1 for one cycle; Slot sequence 1,2,3,0.
2. Strobe gaps:
   - stimulus: same frame with two En=0 cycles between every sample, Din toggling during the gaps;
   - response: identical Dout=4'b1101, Slot holds during gaps, exactly one FrameValid pulse.
3. Early sync:
   - stimulus: locked, Sync=1 arrives when Slot=2 with Din=0;
   - response: SyncErr pulses once, Dout keeps the prior frame, no FrameValid, Slot=1 next cycle, Locked stays 1.
4. Missing sync:
   - stimulus: at Slot=0, En=1 with Sync=0;
   - response: SyncErr pulses, Locked=0, subsequent Din with Sync=0 is ignored (Slot stays 0), the next Sync=1 relocks.
5. Async reset mid-frame:
   - stimulus: Reset=1 between clock edges at Slot=2 after a valid frame;
   - response: Dout=0, Slot=0, Locked=0 without waiting for a Clock edge; after release, the first full frame yields FrameValid only after a new Sync.
6. Non-power-of-two (CHANNELS=3, SLOT_W=2):
   - stimulus: two back-to-back frames Din=1,1,0 then 0,1,1;
   - response: Slot goes 0,1,2,0,1,2,0 and never reaches 3; Dout=3'b011 then 3'b110; two FrameValid pulses 3 cycles apart.
